// File: rtl/mem_arb.sv
// Two-requester memory arbiter: icache/dcache share one memory port with a
// single outstanding transaction, round-robin on ties, timeout and error flagging.
module mem_arb #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_aL,
    input  logic              icache_req_valid,
    input  logic [ADDR_W-1:0] icache_req_block_addr,
    output logic              icache_req_ready,
    output logic              icache_resp_valid,
    output logic [DATA_W-1:0] icache_resp_block_data,
    input  logic              dcache_req_valid,
    input  logic              dcache_req_type,
    input  logic [ADDR_W-1:0] dcache_req_block_addr,
    input  logic [DATA_W-1:0] dcache_req_block_data,
    output logic              dcache_req_ready,
    output logic              dcache_resp_valid,
    output logic [DATA_W-1:0] dcache_resp_block_data,
    output logic              mem_req_valid,
    output logic              mem_req_cache_type,
    output logic              mem_req_type,
    output logic [ADDR_W-1:0] mem_req_block_addr,
    output logic [DATA_W-1:0] mem_req_block_data,
    input  logic              mem_resp_valid,
    input  logic              mem_resp_cache_type,
    input  logic [DATA_W-1:0] mem_resp_block_data,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic              lat_ctype;
    logic              lat_rtype;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              last_grant;  // 0 icache, 1 dcache
    logic [7:0]        cnt;

    logic idle, issue, waiting;
    logic grant_i, grant_d;
    logic resp_match, resp_bad;

    assign idle    = (state == IDLE);
    assign issue   = (state == ISSUE);
    assign waiting = (state == WAIT);

    // On a tie the requester that did not win last time gets the grant.
    assign grant_i = icache_req_valid & (~dcache_req_valid | last_grant);
    assign grant_d = dcache_req_valid & (~icache_req_valid | ~last_grant);

    // Gated by reset so nothing is offered while the block is held in reset.
    assign icache_req_ready = rst_aL & idle & grant_i;
    assign dcache_req_ready = rst_aL & idle & grant_d;

    assign resp_match = waiting & mem_resp_valid & (mem_resp_cache_type == lat_ctype);
    assign resp_bad   = mem_resp_valid & ~resp_match;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state      <= IDLE;
            lat_ctype  <= 1'b0;
            lat_rtype  <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            last_grant <= 1'b1;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            if (resp_bad)
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (icache_req_ready) begin
                        lat_ctype  <= 1'b0;
                        lat_rtype  <= 1'b0;
                        lat_addr   <= icache_req_block_addr;
                        lat_data   <= '0;
                        last_grant <= 1'b0;
                        state      <= ISSUE;
                    end else if (dcache_req_ready) begin
                        lat_ctype  <= 1'b1;
                        lat_rtype  <= dcache_req_type;
                        lat_addr   <= dcache_req_block_addr;
                        lat_data   <= dcache_req_block_data;
                        last_grant <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (resp_match) begin
                        state <= IDLE;
                    end else if (cnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req_valid      = issue;
    assign mem_req_cache_type = issue & lat_ctype;
    assign mem_req_type       = issue & lat_rtype;
    assign mem_req_block_addr = issue ? lat_addr : '0;
    assign mem_req_block_data = issue ? lat_data : '0;

    // Write acks carry no data back to the dcache.
    assign icache_resp_valid      = resp_match & ~lat_ctype;
    assign icache_resp_block_data = icache_resp_valid ? mem_resp_block_data : '0;
    assign dcache_resp_valid      = resp_match & lat_ctype;
    assign dcache_resp_block_data = (dcache_resp_valid & ~lat_rtype) ? mem_resp_block_data : '0;

    assign busy = ~idle;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a per-cycle vector table for basic grant/read/write
// flow, then hand sequences for round-robin, timeout, mismatch and reset.
module tb_mem_arb;
    localparam int AW = 26;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_aL;
    logic          iv, ir, irv;
    logic [AW-1:0] ia;
    logic [DW-1:0] ird;
    logic          dv, dt, dr, drv;
    logic [AW-1:0] da;
    logic [DW-1:0] dd, drd;
    logic          qv, qc, qt;
    logic [AW-1:0] qa;
    logic [DW-1:0] qd;
    logic          mv, mc;
    logic [DW-1:0] md;
    logic          busy, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arb dut (
        .clk(clk), .rst_aL(rst_aL),
        .icache_req_valid(iv), .icache_req_block_addr(ia), .icache_req_ready(ir),
        .icache_resp_valid(irv), .icache_resp_block_data(ird),
        .dcache_req_valid(dv), .dcache_req_type(dt), .dcache_req_block_addr(da),
        .dcache_req_block_data(dd), .dcache_req_ready(dr),
        .dcache_resp_valid(drv), .dcache_resp_block_data(drd),
        .mem_req_valid(qv), .mem_req_cache_type(qc), .mem_req_type(qt),
        .mem_req_block_addr(qa), .mem_req_block_data(qd),
        .mem_resp_valid(mv), .mem_resp_cache_type(mc), .mem_resp_block_data(md),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic iv; logic [AW-1:0] ia;
        logic dv; logic dt; logic [AW-1:0] da; logic [DW-1:0] dd;
        logic mv; logic mc; logic [DW-1:0] md;
        logic e_ir; logic e_dr;
        logic e_qv; logic e_qc; logic e_qt; logic [AW-1:0] e_qa; logic [DW-1:0] e_qd;
        logic e_irv; logic [DW-1:0] e_ird;
        logic e_drv; logic [DW-1:0] e_drd;
        logic e_busy; logic e_err;
    } vec_t;

    function automatic vec_t mk(logic i_v, logic [AW-1:0] i_a, logic d_v, logic d_t,
                                logic [AW-1:0] d_a, logic [DW-1:0] d_d,
                                logic m_v, logic m_c, logic [DW-1:0] m_d);
        vec_t v;
        v = '{default: '0};
        v.iv = i_v; v.ia = i_a; v.dv = d_v; v.dt = d_t; v.da = d_a; v.dd = d_d;
        v.mv = m_v; v.mc = m_c; v.md = m_d;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        iv = 0; ia = '0; dv = 0; dt = 0; da = '0; dd = '0; mv = 0; mc = 0; md = '0;
    endtask

    task automatic do_reset();
        clr_in();
        rst_aL = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_aL = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[20];
    logic saw_bad;
    logic exp_c;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic flow: tie from reset, icache first, then dcache read and write ack.
        tbl[0] = mk(1, 'h100, 1, 0, 'h200, 0, 0, 0, 0);  tbl[0].e_ir = 1;
        tbl[1] = mk(0, 0, 1, 0, 'h200, 0, 0, 0, 0);
        tbl[1].e_qv = 1; tbl[1].e_qa = 'h100; tbl[1].e_busy = 1;
        tbl[2] = mk(0, 0, 1, 0, 'h200, 0, 0, 0, 0);      tbl[2].e_busy = 1;
        tbl[3] = mk(0, 0, 1, 0, 'h200, 0, 1, 0, 'h1111);
        tbl[3].e_irv = 1; tbl[3].e_ird = 'h1111; tbl[3].e_busy = 1;
        tbl[4] = mk(0, 0, 1, 0, 'h200, 0, 0, 0, 0);      tbl[4].e_dr = 1;
        tbl[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5].e_qv = 1; tbl[5].e_qc = 1; tbl[5].e_qa = 'h200; tbl[5].e_busy = 1;
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 1, 1, 'h2222);
        tbl[6].e_drv = 1; tbl[6].e_drd = 'h2222; tbl[6].e_busy = 1;
        tbl[7] = mk(0, 0, 1, 1, 'h40, 'hDEAD_BEEF, 0, 0, 0); tbl[7].e_dr = 1;
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8].e_qv = 1; tbl[8].e_qc = 1; tbl[8].e_qt = 1; tbl[8].e_qa = 'h40;
        tbl[8].e_qd = 'hDEAD_BEEF; tbl[8].e_busy = 1;
        for (int i = 9; i < 18; i++) begin
            tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); tbl[i].e_busy = 1;
        end
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, 1, 'h5555);
        tbl[18].e_drv = 1; tbl[18].e_drd = 0; tbl[18].e_busy = 1;
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            iv = tbl[i].iv; ia = tbl[i].ia; dv = tbl[i].dv; dt = tbl[i].dt;
            da = tbl[i].da; dd = tbl[i].dd; mv = tbl[i].mv; mc = tbl[i].mc; md = tbl[i].md;
            @(negedge clk);
            chk($sformatf("v%0d icache_ready", i), 64'(ir), 64'(tbl[i].e_ir));
            chk($sformatf("v%0d dcache_ready", i), 64'(dr), 64'(tbl[i].e_dr));
            chk($sformatf("v%0d mem_req_valid", i), 64'(qv), 64'(tbl[i].e_qv));
            chk($sformatf("v%0d mem_req_ctype", i), 64'(qc), 64'(tbl[i].e_qc));
            chk($sformatf("v%0d mem_req_type", i), 64'(qt), 64'(tbl[i].e_qt));
            chk($sformatf("v%0d mem_req_addr", i), 64'(qa), 64'(tbl[i].e_qa));
            chk($sformatf("v%0d mem_req_data", i), qd, tbl[i].e_qd);
            chk($sformatf("v%0d icache_resp_valid", i), 64'(irv), 64'(tbl[i].e_irv));
            chk($sformatf("v%0d icache_resp_data", i), ird, tbl[i].e_ird);
            chk($sformatf("v%0d dcache_resp_valid", i), 64'(drv), 64'(tbl[i].e_drv));
            chk($sformatf("v%0d dcache_resp_data", i), drd, tbl[i].e_drd);
            chk($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("v%0d err", i), 64'(err), 64'(tbl[i].e_err));
            tick();
        end

        // Round-robin: both requesters always valid for 8 transactions.
        do_reset();
        for (int t = 0; t < 8; t++) begin
            exp_c = (t % 2) == 1;
            iv = 1; ia = AW'('h10 + t); dv = 1; dt = 0; da = AW'('h20 + t);
            @(negedge clk);
            chk($sformatf("rr%0d icache_ready", t), 64'(ir), 64'(!exp_c));
            chk($sformatf("rr%0d dcache_ready", t), 64'(dr), 64'(exp_c));
            tick();
            @(negedge clk);
            chk($sformatf("rr%0d issue ctype", t), 64'({qv, qc}), 64'({1'b1, exp_c}));
            chk($sformatf("rr%0d ready in issue", t), 64'(ir | dr), 64'(0));
            tick();
            mv = 1; mc = exp_c; md = DW'(t + 1);
            @(negedge clk);
            chk($sformatf("rr%0d resp strobes", t), 64'({irv, drv}), 64'({!exp_c, exp_c}));
            chk($sformatf("rr%0d ready in wait", t), 64'(ir | dr), 64'(0));
            tick();
            mv = 0;
        end
        clr_in();

        // Timeout: no memory response for the full wait window.
        do_reset();
        iv = 1; ia = 'h300;
        @(negedge clk);
        chk("to icache_ready", 64'(ir), 64'(1));
        tick();
        iv = 0;
        tick();
        saw_bad = 0;
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            if (!busy || irv || drv || err) saw_bad = 1;
            tick();
        end
        @(negedge clk);
        chk("to wait window", 64'(saw_bad), 64'(0));
        chk("to busy after", 64'(busy), 64'(0));
        chk("to err after", 64'(err), 64'(1));
        dv = 1; dt = 0; da = 'h400;
        #1;
        chk("to next ready", 64'(dr), 64'(1));
        tick();
        dv = 0;
        @(negedge clk);
        chk("to next mem_req", 64'({qv, qc, qa}), 64'({1'b1, 1'b1, AW'('h400)}));
        tick();
        mv = 1; mc = 1; md = 'h77;
        @(negedge clk);
        chk("to next resp", 64'({drv, drd[7:0]}), 64'({1'b1, 8'h77}));
        tick();
        mv = 0;

        // Mismatched response type while icache is outstanding.
        do_reset();
        iv = 1; ia = 'h100;
        @(negedge clk);
        tick();
        iv = 0;
        tick();
        mv = 1; mc = 1; md = 'h99;
        @(negedge clk);
        chk("mm no strobe", 64'({irv, drv}), 64'(0));
        tick();
        mv = 0;
        @(negedge clk);
        chk("mm err", 64'(err), 64'(1));
        chk("mm still busy", 64'(busy), 64'(1));
        mv = 1; mc = 0; md = 'hABCD;
        #1;
        chk("mm good resp", 64'({irv, ird[15:0]}), 64'({1'b1, 16'hABCD}));
        tick();
        mv = 0;
        @(negedge clk);
        chk("mm idle after", 64'(busy), 64'(0));

        // Reset in WAIT with both requesters valid and err already set.
        do_reset();
        iv = 1; ia = 'h100; dv = 1; da = 'h200;
        @(negedge clk);
        tick();
        tick();
        mv = 1; mc = 1;
        tick();
        mv = 0;
        #2 rst_aL = 1'b0;
        #1;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst err", 64'(err), 64'(0));
        chk("rst readies", 64'({ir, dr}), 64'(0));
        chk("rst mem_req", 64'({qv, qc, qt, qa}), 64'(0));
        tick();
        rst_aL = 1'b1;
        @(negedge clk);
        chk("rst tie grant", 64'({ir, dr}), 64'({1'b1, 1'b0}));
        iv = 0; dv = 0; mv = 1; mc = 0; md = 'h1;
        #1;
        chk("rst stale no strobe", 64'({irv, drv}), 64'(0));
        tick();
        mv = 0;
        @(negedge clk);
        chk("rst stale err", 64'({err, busy}), 64'({1'b1, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
